// File: rtl/dsp_result_collector_if.sv
// Signal bundle between the DSP P output, the result collector and the
// downstream consumer. Port-level names follow the DSP datapath naming.
interface dsp_result_collector_if #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   // Pipeline side
   logic             CE;
   logic             in_valid;
   logic [WIDTH-1:0] P_in;
   logic             flush;

   // Consumer side
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [CW-1:0]    count;
   logic             overflow;

   // Driven by the producer/consumer environment.
   modport master (
      output CE, in_valid, P_in, flush, out_ready,
      input  out_valid, out_data, count, overflow
   );

   // Seen by the collector.
   modport slave (
      input  CE, in_valid, P_in, flush, out_ready,
      output out_valid, out_data, count, overflow
   );
endinterface

// File: rtl/dsp_result_collector.sv
// Result collector for the DSP48A1 datapath. A valid token follows the
// operands through a CE-gated delay line matching the DSP pipeline depth;
// when it emerges, P is captured into a small first-word-fall-through FIFO
// and offered downstream with valid/ready flow control. A dropped capture
// (FIFO full, no pop) sets a sticky overflow flag.
module dsp_result_collector #(
   parameter int WIDTH   = 48,
   parameter int LATENCY = 4,  // 0..7 CE-gated stages
   parameter int DEPTH   = 4   // power of two, >= 2
) (
   input  logic                 clk,
   input  logic                 rst,
   dsp_result_collector_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic             w_tag;
   logic             w_cap;
   logic             w_pop;
   logic             w_empty;
   logic             w_full;
   logic             w_wr;
   logic             w_drop;
   logic [CW-1:0]    w_count_nxt;

   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_overflow;
   logic [WIDTH-1:0] r_mem [DEPTH];

   // ------------------------------------------------------------------
   // Valid-token delay line
   // ------------------------------------------------------------------
   generate
      if (LATENCY == 0) begin : g_no_delay
         // With no pipeline stages the result is valid in the launch cycle.
         assign w_tag = bus.in_valid;
      end else begin : g_delay
         logic [LATENCY-1:0] r_dly;

         // Advance the token in lock-step with the CE-gated DSP registers.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_dly <= '0;
            end else if (bus.flush) begin
               r_dly <= '0;
            end else if (bus.CE) begin
               // NOTE: non-blocking assignments make every stage read the
               // pre-edge value of its neighbour, so the loop order is irrelevant.
               r_dly[0] <= bus.in_valid;
               for (int i = 1; i < LATENCY; i++) begin
                  r_dly[i] <= r_dly[i-1];
               end
            end
         end

         assign w_tag = r_dly[LATENCY-1];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Capture / pop decode
   // ------------------------------------------------------------------
   // A result is only real on a CE cycle: that is when the DSP output
   // register holding it is about to be overwritten.
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_COUNT);
   assign w_cap   = w_tag & bus.CE;
   assign w_pop   = ~w_empty & bus.out_ready;
   // When full, a capture still fits if the head leaves in the same cycle.
   assign w_wr    = w_cap & (~w_full | w_pop);
   assign w_drop  = w_cap & w_full & ~w_pop;

   // Next occupancy: +1 on write only, -1 on pop only, else unchanged.
   always_comb begin
      // NOTE: default first so every path assigns w_count_nxt and no latch
      // is inferred.
      w_count_nxt = r_count;
      case ({w_wr, w_pop})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   // Write captured results into the FIFO array.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; pointers and count define which
      // entries are meaningful, so stale contents are never observed.
      if (w_wr && !bus.flush) begin
         r_mem[r_wr_ptr] <= bus.P_in;
      end
   end

   // Pointers, occupancy and sticky overflow; flush outranks cap and pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (bus.flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         // Pointers are AW bits wide and DEPTH is a power of two, so the
         // natural rollover is the modulo-DEPTH wrap.
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         r_count <= w_count_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // Head of FIFO falls through combinationally; zero when nothing is held.
   assign bus.out_valid = ~w_empty;
   assign bus.out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign bus.count     = r_count;
   assign bus.overflow  = r_overflow;

   // ------------------------------------------------------------------
   // Structural invariants
   // ------------------------------------------------------------------
   // Occupancy can never exceed the array size.
   a_count_bound : assert property (@(posedge clk) disable iff (rst)
      r_count <= FULL_COUNT);

   // Pointer distance always agrees with the occupancy counter.
   a_count_ptrs : assert property (@(posedge clk) disable iff (rst)
      (r_wr_ptr - r_rd_ptr) == r_count[AW-1:0]);

endmodule

// File: tb/tb_dsp_result_collector.sv
// Directed bench for dsp_result_collector. Two instances share clk/rst:
// u_dut_a (LATENCY=4) and u_dut_b (LATENCY=0). Stimulus pushes the expected
// result of every capture into a per-instance queue; a negedge monitor pops
// and compares on every accepted transfer.
`timescale 1ns/1ps
module tb_dsp_result_collector;

   localparam int               WIDTH = 48;
   localparam int               DEPTH = 4;
   localparam logic [WIDTH-1:0] JUNK  = 48'hDEAD_BEEF_0000;

   logic clk = 1'b0;
   logic rst;

   int n_checks = 0;
   int n_fails  = 0;

   logic [WIDTH-1:0] qa[$];
   logic [WIDTH-1:0] qb[$];

   dsp_result_collector_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ifa ();
   dsp_result_collector_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ifb ();

   dsp_result_collector #(.WIDTH(WIDTH), .LATENCY(4), .DEPTH(DEPTH)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   dsp_result_collector #(.WIDTH(WIDTH), .LATENCY(0), .DEPTH(DEPTH)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_a_state(input string tag, input int cnt, input logic ovf);
      check({tag, "_count"}, 64'(ifa.count), 64'(cnt));
      check({tag, "_valid"}, 64'(ifa.out_valid), 64'(cnt != 0));
      check({tag, "_ovf"}, 64'(ifa.overflow), 64'(ovf));
   endtask

   // Apply one cycle of inputs to instance A, just after the rising edge.
   task automatic drv_a(input logic ce, input logic iv, input logic [WIDTH-1:0] p,
                        input logic fl, input logic rdy);
      @(posedge clk);
      #1;
      ifa.CE        = ce;
      ifa.in_valid  = iv;
      ifa.P_in      = p;
      ifa.flush     = fl;
      ifa.out_ready = rdy;
   endtask

   task automatic drv_b(input logic ce, input logic iv, input logic [WIDTH-1:0] p,
                        input logic fl, input logic rdy);
      @(posedge clk);
      #1;
      ifb.CE        = ce;
      ifb.in_valid  = iv;
      ifb.P_in      = p;
      ifb.flush     = fl;
      ifb.out_ready = rdy;
   endtask

   // Scoreboard monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (ifa.out_valid === 1'b1 && ifa.out_ready === 1'b1) begin
         if (qa.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL a_unexpected_pop: got %0h, expected no result", ifa.out_data);
         end else begin
            check("a_pop_data", 64'(ifa.out_data), 64'(qa.pop_front()));
         end
      end else if (ifa.out_valid === 1'b0) begin
         check("a_idle_data_zero", 64'(ifa.out_data), 64'd0);
      end

      if (ifb.out_valid === 1'b1 && ifb.out_ready === 1'b1) begin
         if (qb.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL b_unexpected_pop: got %0h, expected no result", ifb.out_data);
         end else begin
            check("b_pop_data", 64'(ifb.out_data), 64'(qb.pop_front()));
         end
      end else if (ifb.out_valid === 1'b0) begin
         check("b_idle_data_zero", 64'(ifb.out_data), 64'd0);
      end
   end

   // Watchdog: the directed sequence is a few hundred cycles long.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of sequence");
      $fatal(1, "simulation timeout");
   end

   initial begin
      logic [WIDTH-1:0] p;

      rst = 1'b1;
      ifa.CE = 1'b0; ifa.in_valid = 1'b0; ifa.P_in = JUNK; ifa.flush = 1'b0; ifa.out_ready = 1'b0;
      ifb.CE = 1'b0; ifb.in_valid = 1'b0; ifb.P_in = JUNK; ifb.flush = 1'b0; ifb.out_ready = 1'b0;
      #12;

      // ---------------- Reset state ----------------
      check_a_state("reset_a", 0, 1'b0);
      check("reset_a_data", 64'(ifa.out_data), 64'd0);
      check("reset_b_count", 64'(ifb.count), 64'd0);
      check("reset_b_valid", 64'(ifb.out_valid), 64'd0);
      rst = 1'b0;

      // ---------------- Latency, CE=1 throughout ----------------
      drv_a(1'b1, 1'b1, JUNK, 1'b0, 1'b0);               // launch, edge 0
      repeat (3) drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b0);    // edges 1..3
      drv_a(1'b1, 1'b0, 48'h123, 1'b0, 1'b0);            // result present for edge 4
      qa.push_back(48'h123);
      check_a_state("lat_before", 0, 1'b0);
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b0);
      check_a_state("lat_after", 1, 1'b0);
      check("lat_data", 64'(ifa.out_data), 64'h123);
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b1);               // drain
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b0);
      check_a_state("lat_drained", 0, 1'b0);

      // ---------------- Latency with a 2-cycle CE stall mid-flight ----------------
      drv_a(1'b1, 1'b1, JUNK, 1'b0, 1'b0);               // launch, edge 0
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b0);               // edge 1
      drv_a(1'b0, 1'b1, JUNK, 1'b0, 1'b0);               // stall: in_valid ignored
      drv_a(1'b0, 1'b1, JUNK, 1'b0, 1'b0);               // stall
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b0);               // edge 2
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b0);               // edge 3
      drv_a(1'b1, 1'b0, 48'h123, 1'b0, 1'b0);            // edge 4 captures
      qa.push_back(48'h123);
      check_a_state("stall_before", 0, 1'b0);
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b0);
      check_a_state("stall_after", 1, 1'b0);
      check("stall_data", 64'(ifa.out_data), 64'h123);
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b1);
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b0);
      check_a_state("stall_drained", 0, 1'b0);

      // ---------------- Fill and backpressure ----------------
      for (int i = 0; i < 8; i++) begin
         p = (i >= 4) ? 48'(i - 3) : JUNK;
         drv_a(1'b1, (i < 4), p, 1'b0, 1'b0);
         if (i >= 4) qa.push_back(p);
      end
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b0);
      check_a_state("fill_full", 4, 1'b0);
      check("fill_head", 64'(ifa.out_data), 64'd1);
      repeat (4) drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b1);
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b0);
      check_a_state("fill_drained", 0, 1'b0);
      check("fill_drained_data", 64'(ifa.out_data), 64'd0);

      // ---------------- Overflow: 5th capture while full, no pop ----------------
      for (int i = 0; i < 9; i++) begin
         p = (i >= 4) ? 48'(i - 3) : JUNK;
         drv_a(1'b1, (i < 5), p, 1'b0, 1'b0);
         if (i >= 4 && i <= 7) qa.push_back(p);
      end
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b0);
      check_a_state("ovf_set", 4, 1'b1);
      repeat (4) drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b1);
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b0);
      check_a_state("ovf_sticky", 0, 1'b1);
      drv_a(1'b1, 1'b0, JUNK, 1'b1, 1'b0);               // flush clears overflow
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b0);
      check_a_state("ovf_flushed", 0, 1'b0);

      // ---------------- Full with simultaneous capture and pop ----------------
      for (int i = 0; i < 9; i++) begin
         p = (i >= 4) ? 48'(i + 1) : JUNK;                // 5,6,7,8 then 9
         drv_a(1'b1, (i < 5), p, 1'b0, (i == 8));
         if (i >= 4) qa.push_back(p);
      end
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b1);
      check_a_state("pushpop_full", 4, 1'b0);
      check("pushpop_head", 64'(ifa.out_data), 64'd6);
      repeat (3) drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b1);
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b0);
      check_a_state("pushpop_drained", 0, 1'b0);
      check("pushpop_sb_empty", 64'(qa.size()), 64'd0);

      // ---------------- Flush priority over cap and pop ----------------
      drv_a(1'b1, 1'b1, JUNK, 1'b0, 1'b0);               // c0: token 1
      drv_a(1'b1, 1'b1, JUNK, 1'b0, 1'b0);               // c1: token 2
      drv_a(1'b1, 1'b1, JUNK, 1'b0, 1'b0);               // c2: token 3
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b0);               // c3
      drv_a(1'b1, 1'b1, 48'h11, 1'b0, 1'b0);             // c4: token 4 launch, token 1 cap
      qa.push_back(48'h11);
      drv_a(1'b1, 1'b0, 48'h22, 1'b0, 1'b0);             // c5: token 2 cap
      qa.push_back(48'h22);
      drv_a(1'b1, 1'b0, 48'h33, 1'b1, 1'b1);             // c6: flush + cap + pop
      check_a_state("flush_before", 2, 1'b0);
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b1);
      qa.delete();
      check_a_state("flush_after", 0, 1'b0);
      repeat (6) drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b1);    // token 4 must never appear
      check_a_state("flush_no_ghost", 0, 1'b0);

      // ---------------- Asynchronous reset mid-operation ----------------
      for (int i = 0; i < 9; i++) begin
         p = (i >= 4) ? 48'h51 + 48'(i - 4) : JUNK;
         drv_a(1'b1, (i < 5), p, 1'b0, 1'b0);
         if (i >= 4 && i <= 7) qa.push_back(p);
      end
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b1);               // one pop
      check_a_state("arst_full", 4, 1'b1);
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b0);
      check_a_state("arst_pre", 3, 1'b1);
      #2;
      rst = 1'b1;
      qa.delete();
      #1;
      check_a_state("arst_now", 0, 1'b0);
      check("arst_data", 64'(ifa.out_data), 64'd0);
      #3;
      rst = 1'b0;
      drv_a(1'b1, 1'b1, JUNK, 1'b0, 1'b0);
      repeat (3) drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b0);
      drv_a(1'b1, 1'b0, 48'hABC, 1'b0, 1'b0);
      qa.push_back(48'hABC);
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b0);
      check_a_state("arst_post", 1, 1'b0);
      check("arst_post_data", 64'(ifa.out_data), 64'hABC);
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b1);
      drv_a(1'b1, 1'b0, JUNK, 1'b0, 1'b0);
      check_a_state("arst_drained", 0, 1'b0);

      // ---------------- LATENCY=0 instance ----------------
      drv_b(1'b1, 1'b1, 48'd7, 1'b0, 1'b0);              // captured at this edge
      qb.push_back(48'd7);
      check("lat0_before_count", 64'(ifb.count), 64'd0);
      drv_b(1'b0, 1'b1, 48'd8, 1'b0, 1'b0);              // CE=0: no capture
      check("lat0_count", 64'(ifb.count), 64'd1);
      check("lat0_valid", 64'(ifb.out_valid), 64'd1);
      check("lat0_data", 64'(ifb.out_data), 64'd7);
      drv_b(1'b0, 1'b0, JUNK, 1'b0, 1'b0);
      check("lat0_ce0_count", 64'(ifb.count), 64'd1);
      drv_b(1'b0, 1'b0, JUNK, 1'b0, 1'b1);
      drv_b(1'b0, 1'b0, JUNK, 1'b0, 1'b0);
      check("lat0_drained_count", 64'(ifb.count), 64'd0);
      check("lat0_drained_valid", 64'(ifb.out_valid), 64'd0);

      // ---------------- Scoreboards fully consumed ----------------
      drv_a(1'b0, 1'b0, JUNK, 1'b0, 1'b0);
      check("a_sb_empty", 64'(qa.size()), 64'd0);
      check("b_sb_empty", 64'(qb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
